// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// stream framing constants and the word-offset helper.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_HDR_LO = 3'd2,
    ST_LOAD   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int BIDX_W         = $clog2(BYTES_PER_WORD);
  localparam int CNT_W          = HDR_BYTES * 8;

  // Byte offset of word k from the image base.
  function automatic logic [31:0] word_offset(input logic [CNT_W-1:0] k);
    return {{(30-CNT_W){1'b0}}, k, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Big-endian byte-to-word assembler: keeps the three leading bytes and
// completes the word combinationally with the fourth, flagging it for one cycle.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_push,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(BYTES_PER_WORD - 1);

  logic [23:0]       r_shift;
  logic [BIDX_W-1:0] r_idx;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (i_clear) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (i_push) begin
      r_shift <= {r_shift[15:0], i_byte};
      r_idx   <= r_idx + 1'b1;
    end
  end

  assign o_word_valid = i_push & ~i_clear & (r_idx == LAST_IDX);
  assign o_word       = {r_shift, i_byte};

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a length-prefixed byte stream, writes
// big-endian words to consecutive addresses and holds the core in reset meanwhile.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int BASE_ADDR   = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_data,
  output logic              o_in_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [31:0]       o_wr_data,
  output logic              o_cpu_reset,
  output logic              o_done,
  output logic              o_error
);

  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [31:0]       DEPTH = 32'(DEPTH_WORDS);

  state_t            r_state, w_state_d;
  logic [7:0]        r_n_hi;
  logic [CNT_W-1:0]  r_n;
  logic [CNT_W-1:0]  r_word_cnt;
  logic              r_in_ready, r_wr_en, r_cpu_reset, r_done, r_error;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;

  logic              w_hs, w_push, w_clear, w_restart;
  logic              w_word_valid, w_last_word;
  logic [31:0]       w_word;
  logic [CNT_W-1:0]  w_n;
  logic              w_in_ready_d, w_done_d, w_error_d, w_cpu_reset_d;

  assign w_hs        = i_in_valid & r_in_ready;
  assign w_push      = w_hs & (r_state == ST_LOAD);
  assign w_n         = {r_n_hi, i_in_data};
  assign w_last_word = (r_word_cnt == (r_n - 1'b1));

  word_assembler u_asm (
    .i_clk        (i_clk),
    .i_rst        (i_reset),
    .i_clear      (w_clear),
    .i_push       (w_push),
    .i_byte       (i_in_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    w_clear   = 1'b0;
    w_restart = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_start) begin
          w_state_d = ST_HDR_HI;
          w_clear   = 1'b1;
          w_restart = 1'b1;
        end
      end
      ST_HDR_HI: if (w_hs) w_state_d = ST_HDR_LO;
      ST_HDR_LO: begin
        if (w_hs) begin
          w_clear = 1'b1;
          if (w_n == '0)               w_state_d = ST_DONE;
          else if (32'(w_n) > DEPTH)   w_state_d = ST_ERROR;
          else                         w_state_d = ST_LOAD;
        end
      end
      ST_LOAD: if (w_word_valid && w_last_word) w_state_d = ST_DONE;
      default: w_state_d = ST_IDLE;
    endcase

    w_in_ready_d  = (w_state_d == ST_HDR_HI) || (w_state_d == ST_HDR_LO) ||
                    (w_state_d == ST_LOAD);
    w_done_d      = (w_state_d == ST_DONE);
    w_error_d     = (w_state_d == ST_ERROR);
    // Release the core only once DONE has been held for a cycle, so the final write lands first.
    w_cpu_reset_d = !((r_state == ST_DONE) && (w_state_d == ST_DONE));
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_in_ready  <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= BASE;
      r_wr_data   <= '0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_n_hi      <= '0;
      r_n         <= '0;
      r_word_cnt  <= '0;
    end else begin
      r_in_ready  <= w_in_ready_d;
      r_done      <= w_done_d;
      r_error     <= w_error_d;
      r_cpu_reset <= w_cpu_reset_d;
      r_wr_en     <= w_word_valid;
      if ((r_state == ST_HDR_HI) && w_hs) r_n_hi <= i_in_data;
      if ((r_state == ST_HDR_LO) && w_hs) r_n    <= w_n;
      if (w_restart) r_wr_addr <= BASE;
      if (w_clear) begin
        r_word_cnt <= '0;
      end else if (w_word_valid) begin
        r_word_cnt <= r_word_cnt + 1'b1;
        r_wr_addr  <= BASE + ADDR_W'(word_offset(r_word_cnt));
        r_wr_data  <= w_word;
      end
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_wr_en     = r_wr_en;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_cpu_reset = r_cpu_reset;
  assign o_done      = r_done;
  assign o_error     = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal load, empty and oversize images,
// stalled stream, mid-load reset, start handling and a full-depth image.
module tb_imem_loader;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0;
  logic        i_in_valid = 1'b0;
  logic [7:0]  i_in_data = 8'h00;
  logic        o_in_ready, o_wr_en, o_cpu_reset, o_done, o_error;
  logic [31:0] o_wr_addr, o_wr_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic        wq_done[$];
  int          gap_writes = 0;
  logic        prev_hs = 1'b0;

  logic [7:0]  img1[10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                            8'h01, 8'h09, 8'h50, 8'h20};
  logic [31:0] img1_addr[2] = '{32'h0, 32'h4};
  logic [31:0] img1_data[2] = '{32'h20080005, 32'h01095020};

  imem_loader #(.ADDR_W(32), .DEPTH_WORDS(256), .BASE_ADDR(0)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_in_valid  (i_in_valid),
    .i_in_data   (i_in_data),
    .o_in_ready  (o_in_ready),
    .o_wr_en     (o_wr_en),
    .o_wr_addr   (o_wr_addr),
    .o_wr_data   (o_wr_data),
    .o_cpu_reset (o_cpu_reset),
    .o_done      (o_done),
    .o_error     (o_error)
  );

  always #5 i_clk = ~i_clk;

  // Log writes; a write not preceded by an accepted byte is a write during a gap.
  always @(negedge i_clk) begin
    if (o_wr_en === 1'b1) begin
      wq_addr.push_back(o_wr_addr);
      wq_data.push_back(o_wr_data);
      wq_done.push_back(o_done);
      if (!prev_hs) gap_writes++;
    end
    prev_hs = (i_in_valid === 1'b1) && (o_in_ready === 1'b1);
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_log;
    wq_addr.delete();
    wq_data.delete();
    wq_done.delete();
    gap_writes = 0;
  endtask

  task automatic do_reset;
    i_reset = 1'b1;
    i_start = 1'b0;
    i_in_valid = 1'b0;
    i_in_data = 8'h00;
    tick;
    tick;
    i_reset = 1'b0;
    tick;
    clear_log();
  endtask

  task automatic pulse_start;
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
  endtask

  // Present one byte after `gap` idle cycles and hold it until accepted.
  task automatic send(input logic [7:0] b, input int gap);
    int budget;
    if (gap > 0) begin
      i_in_valid = 1'b0;
      repeat (gap) tick;
    end
    i_in_valid = 1'b1;
    i_in_data  = b;
    budget = 0;
    while (o_in_ready !== 1'b1 && budget < 20) begin
      tick;
      budget++;
    end
    if (o_in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%b required 1 for byte %h", o_in_ready, b);
    end else begin
      tick;
    end
  endtask

  task automatic send_img1(input int from, input int to, input int maxgap);
    for (int i = from; i <= to; i++)
      send(img1[i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
    i_in_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2 i_reset = 1'b1;
    #2;
    checks++; if (o_in_ready !== 1'b0)    begin errors++; $display("FAIL rst_ready: got %b required 0", o_in_ready); end
    checks++; if (o_wr_en !== 1'b0)       begin errors++; $display("FAIL rst_wr_en: got %b required 0", o_wr_en); end
    checks++; if (o_wr_addr !== 32'h0)    begin errors++; $display("FAIL rst_wr_addr: got %h required 0", o_wr_addr); end
    checks++; if (o_wr_data !== 32'h0)    begin errors++; $display("FAIL rst_wr_data: got %h required 0", o_wr_data); end
    checks++; if (o_cpu_reset !== 1'b1)   begin errors++; $display("FAIL rst_cpu_reset: got %b required 1", o_cpu_reset); end
    checks++; if (o_done !== 1'b0)        begin errors++; $display("FAIL rst_done: got %b required 0", o_done); end
    checks++; if (o_error !== 1'b0)       begin errors++; $display("FAIL rst_error: got %b required 0", o_error); end
    tick;
    i_reset = 1'b0;
    repeat (3) tick;
    checks++; if (o_in_ready !== 1'b0)    begin errors++; $display("FAIL idle_ready: got %b required 0", o_in_ready); end
    checks++; if (o_cpu_reset !== 1'b1)   begin errors++; $display("FAIL idle_cpu_reset: got %b required 1", o_cpu_reset); end
  endtask

  task automatic test_basic_load;
    do_reset();
    pulse_start();
    checks++; if (o_in_ready !== 1'b1)    begin errors++; $display("FAIL t1_hdr_ready: got %b required 1", o_in_ready); end
    send_img1(0, 9, 0);
    checks++; if (o_wr_en !== 1'b1)       begin errors++; $display("FAIL t1_last_wr_en: got %b required 1", o_wr_en); end
    checks++; if (o_done !== 1'b1)        begin errors++; $display("FAIL t1_done_with_wr: got %b required 1", o_done); end
    checks++; if (o_cpu_reset !== 1'b1)   begin errors++; $display("FAIL t1_cpu_reset_held: got %b required 1", o_cpu_reset); end
    checks++; if (o_in_ready !== 1'b0)    begin errors++; $display("FAIL t1_done_ready: got %b required 0", o_in_ready); end
    tick;
    checks++; if (o_cpu_reset !== 1'b0)   begin errors++; $display("FAIL t1_cpu_reset_fall: got %b required 0", o_cpu_reset); end
    checks++; if (o_wr_en !== 1'b0)       begin errors++; $display("FAIL t1_wr_en_drop: got %b required 0", o_wr_en); end
    tick;
    checks++; if (wq_addr.size() != 2)    begin errors++; $display("FAIL t1_nwrites: got %0d required 2", wq_addr.size()); end
    for (int i = 0; i < 2 && i < wq_addr.size(); i++) begin
      checks++; if (wq_addr[i] !== img1_addr[i]) begin errors++; $display("FAIL t1_addr%0d: got %h required %h", i, wq_addr[i], img1_addr[i]); end
      checks++; if (wq_data[i] !== img1_data[i]) begin errors++; $display("FAIL t1_data%0d: got %h required %h", i, wq_data[i], img1_data[i]); end
    end
    if (wq_done.size() == 2) begin
      checks++; if (wq_done[0] !== 1'b0)  begin errors++; $display("FAIL t1_done_early: got %b required 0", wq_done[0]); end
    end
  endtask

  task automatic test_empty_image;
    do_reset();
    pulse_start();
    send(8'h00, 0);
    send(8'h00, 0);
    i_in_valid = 1'b0;
    checks++; if (o_done !== 1'b1)        begin errors++; $display("FAIL t2_done: got %b required 1", o_done); end
    checks++; if (o_cpu_reset !== 1'b1)   begin errors++; $display("FAIL t2_cpu_reset_held: got %b required 1", o_cpu_reset); end
    tick;
    checks++; if (o_cpu_reset !== 1'b0)   begin errors++; $display("FAIL t2_cpu_reset_fall: got %b required 0", o_cpu_reset); end
    tick;
    checks++; if (wq_addr.size() != 0)    begin errors++; $display("FAIL t2_nwrites: got %0d required 0", wq_addr.size()); end
  endtask

  task automatic test_oversize;
    do_reset();
    pulse_start();
    send(8'h01, 0);
    send(8'h01, 0);
    checks++; if (o_error !== 1'b1)       begin errors++; $display("FAIL t3_error: got %b required 1", o_error); end
    checks++; if (o_in_ready !== 1'b0)    begin errors++; $display("FAIL t3_ready: got %b required 0", o_in_ready); end
    repeat (4) tick;
    i_in_valid = 1'b0;
    checks++; if (o_error !== 1'b1)       begin errors++; $display("FAIL t3_error_hold: got %b required 1", o_error); end
    checks++; if (o_cpu_reset !== 1'b1)   begin errors++; $display("FAIL t3_cpu_reset: got %b required 1", o_cpu_reset); end
    checks++; if (o_done !== 1'b0)        begin errors++; $display("FAIL t3_done: got %b required 0", o_done); end
    checks++; if (wq_addr.size() != 0)    begin errors++; $display("FAIL t3_nwrites: got %0d required 0", wq_addr.size()); end
  endtask

  task automatic test_gaps;
    do_reset();
    pulse_start();
    send_img1(0, 9, 5);
    checks++; if (o_done !== 1'b1)        begin errors++; $display("FAIL t4_done: got %b required 1", o_done); end
    repeat (2) tick;
    checks++; if (wq_addr.size() != 2)    begin errors++; $display("FAIL t4_nwrites: got %0d required 2", wq_addr.size()); end
    for (int i = 0; i < 2 && i < wq_addr.size(); i++) begin
      checks++; if (wq_addr[i] !== img1_addr[i]) begin errors++; $display("FAIL t4_addr%0d: got %h required %h", i, wq_addr[i], img1_addr[i]); end
      checks++; if (wq_data[i] !== img1_data[i]) begin errors++; $display("FAIL t4_data%0d: got %h required %h", i, wq_data[i], img1_data[i]); end
    end
    checks++; if (gap_writes != 0)        begin errors++; $display("FAIL t4_gap_write: got %0d required 0", gap_writes); end
  endtask

  task automatic test_mid_reset;
    do_reset();
    pulse_start();
    send_img1(0, 5, 0);
    #2 i_reset = 1'b1;
    #1;
    checks++; if (o_wr_en !== 1'b0)       begin errors++; $display("FAIL t5_wr_en: got %b required 0", o_wr_en); end
    checks++; if (o_in_ready !== 1'b0)    begin errors++; $display("FAIL t5_ready: got %b required 0", o_in_ready); end
    checks++; if (o_wr_addr !== 32'h0)    begin errors++; $display("FAIL t5_wr_addr: got %h required 0", o_wr_addr); end
    checks++; if (o_wr_data !== 32'h0)    begin errors++; $display("FAIL t5_wr_data: got %h required 0", o_wr_data); end
    checks++; if (o_cpu_reset !== 1'b1)   begin errors++; $display("FAIL t5_cpu_reset: got %b required 1", o_cpu_reset); end
    tick;
    i_reset = 1'b0;
    tick;
    clear_log();
    pulse_start();
    send_img1(0, 9, 0);
    repeat (2) tick;
    checks++; if (wq_addr.size() != 2)    begin errors++; $display("FAIL t5_nwrites: got %0d required 2", wq_addr.size()); end
    for (int i = 0; i < 2 && i < wq_addr.size(); i++) begin
      checks++; if (wq_addr[i] !== img1_addr[i]) begin errors++; $display("FAIL t5_addr%0d: got %h required %h", i, wq_addr[i], img1_addr[i]); end
      checks++; if (wq_data[i] !== img1_data[i]) begin errors++; $display("FAIL t5_data%0d: got %h required %h", i, wq_data[i], img1_data[i]); end
    end
  endtask

  task automatic test_start_handling;
    do_reset();
    pulse_start();
    send_img1(0, 3, 0);
    pulse_start();
    send_img1(4, 9, 0);
    repeat (2) tick;
    checks++; if (wq_addr.size() != 2)    begin errors++; $display("FAIL t6_nwrites: got %0d required 2", wq_addr.size()); end
    for (int i = 0; i < 2 && i < wq_addr.size(); i++) begin
      checks++; if (wq_data[i] !== img1_data[i]) begin errors++; $display("FAIL t6_data%0d: got %h required %h", i, wq_data[i], img1_data[i]); end
    end
    checks++; if (o_cpu_reset !== 1'b0)   begin errors++; $display("FAIL t6_released: got %b required 0", o_cpu_reset); end
    pulse_start();
    checks++; if (o_cpu_reset !== 1'b1)   begin errors++; $display("FAIL t6_restart_cpu_reset: got %b required 1", o_cpu_reset); end
    checks++; if (o_done !== 1'b0)        begin errors++; $display("FAIL t6_restart_done: got %b required 0", o_done); end
    checks++; if (o_in_ready !== 1'b1)    begin errors++; $display("FAIL t6_restart_ready: got %b required 1", o_in_ready); end
    checks++; if (o_wr_addr !== 32'h0)    begin errors++; $display("FAIL t6_restart_addr: got %h required 0", o_wr_addr); end
    clear_log();
    send(8'h00, 0); send(8'h01, 0);
    send(8'hDE, 0); send(8'hAD, 0); send(8'hBE, 0); send(8'hEF, 0);
    i_in_valid = 1'b0;
    repeat (2) tick;
    checks++; if (wq_addr.size() != 1)    begin errors++; $display("FAIL t6_reload_nwrites: got %0d required 1", wq_addr.size()); end
    if (wq_addr.size() == 1) begin
      checks++; if (wq_addr[0] !== 32'h0)        begin errors++; $display("FAIL t6_reload_addr: got %h required 0", wq_addr[0]); end
      checks++; if (wq_data[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL t6_reload_data: got %h required deadbeef", wq_data[0]); end
    end
    checks++; if (o_done !== 1'b1)        begin errors++; $display("FAIL t6_reload_done: got %b required 1", o_done); end
  endtask

  // N == DEPTH_WORDS is the largest accepted image; word k is {k, ~k, A5, 5A}.
  task automatic test_full_depth;
    int bad;
    logic [7:0] k8;
    do_reset();
    pulse_start();
    send(8'h01, 0);
    send(8'h00, 0);
    checks++; if (o_error !== 1'b0)       begin errors++; $display("FAIL t7_no_error: got %b required 0", o_error); end
    for (int k = 0; k < 256; k++) begin
      k8 = 8'(k);
      send(k8, 0); send(~k8, 0); send(8'hA5, 0); send(8'h5A, 0);
    end
    i_in_valid = 1'b0;
    checks++; if (o_done !== 1'b1)        begin errors++; $display("FAIL t7_done: got %b required 1", o_done); end
    checks++; if (o_wr_addr !== 32'h3FC)  begin errors++; $display("FAIL t7_last_addr: got %h required 3fc", o_wr_addr); end
    checks++; if (o_wr_data !== 32'hFF00A55A) begin errors++; $display("FAIL t7_last_data: got %h required ff00a55a", o_wr_data); end
    repeat (2) tick;
    checks++; if (wq_addr.size() != 256)  begin errors++; $display("FAIL t7_nwrites: got %0d required 256", wq_addr.size()); end
    bad = 0;
    for (int k = 0; k < wq_addr.size(); k++) begin
      k8 = 8'(k);
      if (wq_addr[k] !== 32'(k * 4) || wq_data[k] !== {k8, ~k8, 16'hA55A}) bad++;
    end
    checks++; if (bad != 0)               begin errors++; $display("FAIL t7_word_contents: got %0d bad words required 0", bad); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_empty_image();
    test_oversize();
    test_gaps();
    test_mid_reset();
    test_start_handling();
    test_full_depth();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
